// File: rtl/timer_ctrl.sv
// ============================================================================
// timer_ctrl : prescaled down-counting timer, 4-entry register map, sticky irq
// Rev 1.0
// ============================================================================
`default_nettype none

module timer_ctrl #(
  parameter int CNT_W = 16,
  parameter int PSC_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [1:0]       i_addr,
  input  logic             i_we,
  input  logic [CNT_W-1:0] i_wdata,
  output logic [CNT_W-1:0] o_rdata,
  output logic             o_irq,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           r_state;
  logic             r_en;
  logic             r_auto;
  logic             r_irq;
  logic [CNT_W-1:0] r_load;
  logic [PSC_W-1:0] r_psc;
  logic [PSC_W-1:0] r_psc_div;
  logic [PSC_W-1:0] r_psc_cnt;
  logic [CNT_W-1:0] r_cnt;

  logic w_wr_ctrl;
  logic w_wr_load;
  logic w_wr_psc;
  logic w_irq_clr;
  logic w_stop;

  assign w_wr_ctrl = i_we && (i_addr == 2'b00);
  assign w_wr_load = i_we && (i_addr == 2'b01);
  assign w_wr_psc  = i_we && (i_addr == 2'b10);
  assign w_irq_clr = w_wr_ctrl && i_wdata[2];
  assign w_stop    = w_wr_ctrl && !i_wdata[0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_en      <= 1'b0;
      r_auto    <= 1'b0;
      r_irq     <= 1'b0;
      r_load    <= '0;
      r_psc     <= '0;
      r_psc_div <= '0;
      r_psc_cnt <= '0;
      r_cnt     <= '0;
    end else begin
      if (w_wr_load) r_load <= i_wdata;
      if (w_wr_psc)  r_psc  <= i_wdata[PSC_W-1:0];
      if (w_wr_ctrl) begin
        r_en   <= i_wdata[0];
        r_auto <= i_wdata[1];
      end
      // Clear first so that a same-edge expiry below overrides it.
      if (w_irq_clr) r_irq <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_wr_ctrl && i_wdata[0]) r_state <= ARM;
        end
        ARM: begin
          if (w_stop) begin
            r_state <= IDLE;
          end else begin
            r_cnt     <= r_load;
            r_psc_div <= r_psc;
            r_psc_cnt <= '0;
            if (r_load == '0) begin
              r_state <= DONE;
              r_irq   <= 1'b1;
            end else begin
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          if (w_stop) begin
            r_state <= IDLE;
          end else if (r_psc_cnt == r_psc_div) begin
            r_psc_cnt <= '0;
            if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
            if (r_cnt <= CNT_W'(1)) begin
              r_state <= DONE;
              r_irq   <= 1'b1;
            end
          end else begin
            r_psc_cnt <= r_psc_cnt + 1'b1;
          end
        end
        DONE: begin
          if (w_stop) begin
            r_state <= IDLE;
          end else if (r_auto) begin
            r_state <= ARM;
          end else begin
            r_state <= IDLE;
            r_en    <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    o_rdata = '0;
    case (i_addr)
      2'b00:   o_rdata = {{(CNT_W-3){1'b0}}, r_irq, r_auto, r_en};
      2'b01:   o_rdata = r_load;
      2'b10:   o_rdata = {{(CNT_W-PSC_W){1'b0}}, r_psc};
      default: o_rdata = r_cnt;
    endcase
  end

  assign o_irq  = r_irq;
  assign o_busy = (r_state != IDLE);
  assign o_cnt  = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_timer_ctrl.sv
// ============================================================================
// tb_timer_ctrl : self-checking bench for timer_ctrl with expected-value queue
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_timer_ctrl;

  localparam int CNT_W = 16;
  localparam int PSC_W = 8;

  logic             i_clk;
  logic             i_rst;
  logic [1:0]       i_addr;
  logic             i_we;
  logic [CNT_W-1:0] i_wdata;
  logic [CNT_W-1:0] o_rdata;
  logic             o_irq;
  logic             o_busy;
  logic [CNT_W-1:0] o_cnt;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [CNT_W-1:0] cnt;
    logic             busy;
    logic             irq;
  } exp_t;

  exp_t sb[$];

  timer_ctrl #(.CNT_W(CNT_W), .PSC_W(PSC_W)) u_dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_addr  (i_addr),
    .i_we    (i_we),
    .i_wdata (i_wdata),
    .o_rdata (o_rdata),
    .o_irq   (o_irq),
    .o_busy  (o_busy),
    .o_cnt   (o_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [CNT_W-1:0] got,
                       input logic [CNT_W-1:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [CNT_W-1:0] d);
    i_addr  = a;
    i_wdata = d;
    i_we    = 1'b1;
    tick();
    i_we    = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [1:0] a,
                    input logic [CNT_W-1:0] exp);
    i_addr = a;
    #1;
    check(tag, o_rdata, exp);
  endtask

  // One timer period starting at the ARM edge: closed-form count-down sequence.
  task automatic push_period(input int l, input int p, input logic irq0,
                             input logic auto_on);
    exp_t e;
    int   n;
    n = l * (p + 1);
    e.cnt = CNT_W'(l); e.busy = 1'b1; e.irq = irq0;
    sb.push_back(e);
    for (int t = 1; t <= n; t++) begin
      e.cnt  = CNT_W'(l - t / (p + 1));
      e.busy = 1'b1;
      e.irq  = (t == n) ? 1'b1 : irq0;
      sb.push_back(e);
    end
    e.cnt = '0; e.busy = auto_on; e.irq = 1'b1;
    sb.push_back(e);
  endtask

  task automatic run_sb(input string tag);
    exp_t e;
    int   k;
    k = 0;
    while (sb.size() > 0) begin
      tick();
      i_we = 1'b0;
      e = sb.pop_front();
      check($sformatf("%s cnt[%0d]", tag, k), o_cnt, e.cnt);
      check($sformatf("%s busy[%0d]", tag, k), CNT_W'(o_busy), CNT_W'(e.busy));
      check($sformatf("%s irq[%0d]", tag, k), CNT_W'(o_irq), CNT_W'(e.irq));
      k++;
    end
  endtask

  initial begin
    i_rst = 1'b1; i_addr = 2'b00; i_we = 1'b0; i_wdata = '0;

    // Reset
    tick(); tick();
    i_rst = 1'b0;
    check("rst irq", CNT_W'(o_irq), 0);
    check("rst busy", CNT_W'(o_busy), 0);
    check("rst cnt", o_cnt, 0);
    for (int a = 0; a < 4; a++) rd($sformatf("rst rdata%0d", a), 2'(a), 0);

    // One-shot LOAD=5 PSC=0
    wr(2'b01, 16'd5);
    wr(2'b10, 16'd0);
    wr(2'b00, 16'h0001);
    push_period(5, 0, 1'b0, 1'b0);
    run_sb("oneshot");
    rd("oneshot ctrl", 2'b00, 16'h0004);

    // Auto-reload LOAD=2 PSC=3, period 10
    wr(2'b00, 16'h0004);
    check("clr irq", CNT_W'(o_irq), 0);
    wr(2'b01, 16'd2);
    wr(2'b10, 16'd3);
    wr(2'b00, 16'h0003);
    push_period(2, 3, 1'b0, 1'b1);
    push_period(2, 3, 1'b1, 1'b1);
    run_sb("auto");
    i_addr = 2'b00; i_wdata = 16'h0007; i_we = 1'b1;
    push_period(2, 3, 1'b0, 1'b1);
    run_sb("auto clr");

    // Unmapped address and we=0 leave registers alone
    wr(2'b00, 16'h0000);
    check("stop busy", CNT_W'(o_busy), 0);
    wr(2'b00, 16'h0004);
    wr(2'b01, 16'h1234);
    wr(2'b10, 16'hFF56);
    wr(2'b00, 16'h0002);
    rd("map load", 2'b01, 16'h1234);
    rd("map psc", 2'b10, 16'h0056);
    rd("map ctrl", 2'b00, 16'h0002);
    wr(2'b11, 16'hFFFF);
    i_addr = 2'b01; i_wdata = 16'h0000; i_we = 1'b0;
    tick();
    rd("nowr load", 2'b01, 16'h1234);
    rd("nowr psc", 2'b10, 16'h0056);
    rd("nowr ctrl", 2'b00, 16'h0002);
    check("nowr busy", CNT_W'(o_busy), 0);

    // Stop mid-run, then reset mid-run
    wr(2'b01, 16'd6);
    wr(2'b10, 16'd0);
    wr(2'b00, 16'h0001);
    repeat (4) tick();
    check("mid cnt", o_cnt, 3);
    wr(2'b00, 16'h0000);
    check("stop cnt", o_cnt, 3);
    check("stop busy2", CNT_W'(o_busy), 0);
    check("stop irq", CNT_W'(o_irq), 0);
    repeat (3) tick();
    check("stop hold", o_cnt, 3);
    wr(2'b00, 16'h0001);
    repeat (4) tick();
    check("mid cnt2", o_cnt, 3);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check("mrst cnt", o_cnt, 0);
    check("mrst busy", CNT_W'(o_busy), 0);
    check("mrst irq", CNT_W'(o_irq), 0);
    rd("mrst load", 2'b01, 16'h0000);
    rd("mrst ctrl", 2'b00, 16'h0000);

    // LOAD=0: ARM then DONE; expiry beats same-edge clear
    wr(2'b01, 16'd0);
    wr(2'b00, 16'h0003);
    check("zero arm busy", CNT_W'(o_busy), 1);
    check("zero arm irq", CNT_W'(o_irq), 0);
    wr(2'b00, 16'h0007);
    check("zero done irq", CNT_W'(o_irq), 1);
    check("zero done busy", CNT_W'(o_busy), 1);
    check("zero done cnt", o_cnt, 0);
    wr(2'b00, 16'h0004);
    check("zero stop irq", CNT_W'(o_irq), 0);
    check("zero stop busy", CNT_W'(o_busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
